// File: rtl/mesh_job_sequencer.sv
// Job sequencer for the mesh core: weight preload, start pulse,
// fixed-latency wait, then result hand-off over valid/ready.
module mesh_job_sequencer #(
  parameter int DW             = 8,
  parameter int ROWS           = 2,
  parameter int COLS           = 4,
  parameter int ROW_W          = 1,
  parameter int COL_W          = 2,
  parameter int COMPUTE_CYCLES = 10,
  parameter int TMR_W          = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     x_valid,
  output logic                     x_ready,
  input  logic                     x_load,
  input  logic [COLS*DW-1:0]       x_vector,
  input  logic                     w_valid,
  output logic                     w_ready,
  input  logic [DW-1:0]            w_data,
  output logic                     preload_valid,
  output logic [ROW_W+COL_W-1:0]   preload_addr,
  output logic [DW-1:0]            preload_data,
  output logic                     start,
  output logic [COLS*DW-1:0]       x_vector_flat,
  input  logic [ROWS*2*DW-1:0]     result_flat,
  output logic                     r_valid,
  input  logic                     r_ready,
  output logic [ROWS*2*DW-1:0]     r_data,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, START, RUN, OUT
  } state_e;

  state_e state_q, state_d;

  logic [ROW_W-1:0]         row_q;
  logic [COL_W-1:0]         col_q;
  logic [TMR_W-1:0]         tmr_q;
  logic                     wt_loaded_q;
  logic                     pv_q;
  logic [ROW_W+COL_W-1:0]   pa_q;
  logic [DW-1:0]            pd_q;
  logic [COLS*DW-1:0]       xv_q;
  logic                     rv_q;
  logic [ROWS*2*DW-1:0]     rd_q;

  logic x_hs, w_hs;
  logic last_col, last_row, tmr_zero;

  assign x_hs     = x_valid & x_ready;
  assign w_hs     = w_valid & w_ready;
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));
  assign tmr_zero = (tmr_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (x_hs)
                 state_d = (x_load || !wt_loaded_q) ? LOAD : START;
      LOAD:    if (w_hs && last_col && last_row) state_d = SETTLE;
      SETTLE:  state_d = START;
      START:   state_d = RUN;
      RUN:     if (tmr_zero) state_d = OUT;
      OUT:     if (r_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // x_ready is gated by rst_n so it reads 0 while reset is held
  always_comb begin
    x_ready = (state_q == IDLE) & rst_n;
    w_ready = (state_q == LOAD);
    start   = (state_q == START);
    busy    = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q       <= '0;
      col_q       <= '0;
      tmr_q       <= '0;
      wt_loaded_q <= 1'b0;
      pv_q        <= 1'b0;
      pa_q        <= '0;
      pd_q        <= '0;
      xv_q        <= '0;
      rv_q        <= 1'b0;
      rd_q        <= '0;
    end else begin
      pv_q <= w_hs;
      if (x_hs) begin
        xv_q  <= x_vector;
        row_q <= '0;
        col_q <= '0;
      end
      if (w_hs) begin
        pa_q <= {row_q, col_q};
        pd_q <= w_data;
        if (last_col) begin
          col_q <= '0;
          row_q <= last_row ? '0 : row_q + 1'b1;
          if (last_row) wt_loaded_q <= 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
      if (state_q == START)
        tmr_q <= TMR_W'(COMPUTE_CYCLES - 1);
      else if (state_q == RUN && !tmr_zero)
        tmr_q <= tmr_q - 1'b1;
      if (state_q == RUN && tmr_zero) begin
        rd_q <= result_flat;
        rv_q <= 1'b1;
      end else if (state_q == OUT && r_ready) begin
        rv_q <= 1'b0;
      end
    end
  end

  assign preload_valid = pv_q;
  assign preload_addr  = pa_q;
  assign preload_data  = pd_q;
  assign x_vector_flat = xv_q;
  assign r_valid       = rv_q;
  assign r_data        = rd_q;

endmodule

// File: tb/tb_mesh_job_sequencer.sv
// Randomized bench for mesh_job_sequencer with a job-level
// reference model (expected preload stream, start and result timing).
module tb_mesh_job_sequencer;
  localparam int DW = 8;
  localparam int ROWS = 2;
  localparam int COLS = 4;
  localparam int NW = ROWS * COLS;
  localparam int CC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x_valid = 1'b0;
  logic x_ready;
  logic x_load = 1'b0;
  logic [COLS*DW-1:0] x_vector = '0;
  logic w_valid = 1'b0;
  logic w_ready;
  logic [DW-1:0] w_data = '0;
  logic preload_valid;
  logic [2:0] preload_addr;
  logic [DW-1:0] preload_data;
  logic start;
  logic [COLS*DW-1:0] x_vector_flat;
  logic [ROWS*2*DW-1:0] result_flat = '0;
  logic r_valid;
  logic r_ready = 1'b0;
  logic [ROWS*2*DW-1:0] r_data;
  logic busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit m_loaded = 0;

  logic [31:0] res_hist [int];
  int pl_c[$];
  logic [2:0] pl_a[$];
  logic [7:0] pl_d[$];
  int st_c[$];

  mesh_job_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .x_valid(x_valid), .x_ready(x_ready),
    .x_load(x_load), .x_vector(x_vector),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .preload_valid(preload_valid),
    .preload_addr(preload_addr),
    .preload_data(preload_data),
    .start(start), .x_vector_flat(x_vector_flat),
    .result_flat(result_flat),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    #3;
    result_flat = $urandom;
    res_hist[cyc] = result_flat;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (preload_valid) begin
        pl_c.push_back(cyc);
        pl_a.push_back(preload_addr);
        pl_d.push_back(preload_data);
      end
      if (start) st_c.push_back(cyc);
    end
  end

  task automatic clear_log();
    pl_c.delete(); pl_a.delete(); pl_d.delete();
    st_c.delete();
  endtask

  task automatic check_all_zero(input string nm);
    logic [80:0] o;
    o = {x_ready, w_ready, preload_valid, preload_addr,
         preload_data, start, x_vector_flat, r_valid,
         r_data, busy};
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL %s outputs=%h required 0", nm, o);
    end
  endtask

  task automatic send_x(input logic ld, input logic [31:0] vec,
                        output int t, output bit ok);
    ok = 0; t = 0;
    @(posedge clk); #2;
    x_valid = 1; x_load = ld; x_vector = vec;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (x_ready) begin t = cyc; ok = 1; break; end
      @(posedge clk); #2;
    end
    @(posedge clk); #2;
    x_valid = 0; x_load = 1'($urandom); x_vector = $urandom;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL x_accept got=0 required=1");
    end
  endtask

  task automatic feed_w(input int mode, input int n,
                        input logic [7:0] wv [NW],
                        output int hc [NW], output int got);
    int p;
    p = 0; got = 0;
    for (int i = 0; i < NW; i++) hc[i] = 0;
    for (int i = 0; i < 300 && got < n; i++) begin
      case (mode)
        0: w_valid = 1;
        1: w_valid = (p % 3 == 0);
        default: w_valid = 1'($urandom_range(0, 1));
      endcase
      w_data = wv[got];
      p++;
      @(negedge clk);
      if (w_valid && w_ready) begin hc[got] = cyc; got++; end
      @(posedge clk); #2;
    end
    w_valid = 0; w_data = $urandom;
  endtask

  task automatic run_job(input bit ld, input int mode,
                         input int rhold);
    logic [31:0] vec, expd;
    logic [7:0] wv [NW];
    int hc [NW];
    int t, got, s, rv, exp_s;
    bit ok, need;
    vec = $urandom;
    for (int i = 0; i < NW; i++) wv[i] = 8'($urandom);
    for (int i = 0; i < NW; i++) hc[i] = 0;
    clear_log();
    need = ld || !m_loaded;
    send_x(ld, vec, t, ok);
    if (!ok) return;
    got = NW;
    if (need) begin
      feed_w(mode, NW, wv, hc, got);
      checks++;
      if (got != NW) begin
        errors++;
        $display("FAIL w_accept got=%0d required=%0d", got, NW);
        return;
      end
    end
    ok = 0; rv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (r_valid) begin rv = cyc; ok = 1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL r_valid_timeout got=0 required=1");
      return;
    end
    checks++;
    if (pl_c.size() != (need ? NW : 0)) begin
      errors++;
      $display("FAIL preload_count got=%0d required=%0d",
               pl_c.size(), need ? NW : 0);
    end
    for (int i = 0; i < pl_c.size() && i < NW && need; i++) begin
      checks++;
      if (pl_a[i] !== 3'(i) || pl_d[i] !== wv[i] ||
          pl_c[i] != hc[i] + 1) begin
        errors++;
        $display("FAIL preload_%0d got a=%0d d=%h c=%0d required a=%0d d=%h c=%0d",
                 i, pl_a[i], pl_d[i], pl_c[i], i, wv[i], hc[i] + 1);
      end
    end
    checks++;
    if (st_c.size() != 1) begin
      errors++;
      $display("FAIL start_count got=%0d required=1", st_c.size());
    end
    s = (st_c.size() > 0) ? st_c[0] : 0;
    exp_s = need ? hc[NW-1] + 2 : t + 1;
    checks++;
    if (s != exp_s) begin
      errors++;
      $display("FAIL start_cycle got=%0d required=%0d", s, exp_s);
    end
    checks++;
    if (rv != s + CC + 1) begin
      errors++;
      $display("FAIL r_valid_cycle got=%0d required=%0d", rv, s + CC + 1);
    end
    expd = res_hist[s + CC];
    checks++;
    if (r_data !== expd) begin
      errors++;
      $display("FAIL r_data got=%h required=%h", r_data, expd);
    end
    checks++;
    if (x_vector_flat !== vec) begin
      errors++;
      $display("FAIL x_vector_flat got=%h required=%h", x_vector_flat, vec);
    end
    for (int h = 0; h < rhold; h++) begin
      @(posedge clk); #2;
      x_valid = 1; x_vector = $urandom;
      @(negedge clk);
      checks++;
      if (r_data !== expd || x_ready !== 1'b0 || busy !== 1'b1 ||
          r_valid !== 1'b1 || x_vector_flat !== vec) begin
        errors++;
        $display("FAIL hold_%0d got rd=%h xr=%b bz=%b rv=%b xv=%h required rd=%h xr=0 bz=1 rv=1 xv=%h",
                 h, r_data, x_ready, busy, r_valid, x_vector_flat, expd, vec);
      end
    end
    @(posedge clk); #2;
    x_valid = 0; r_ready = 1;
    @(posedge clk); #2;
    r_ready = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || x_ready !== 1'b1 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL release got bz=%b xr=%b rv=%b required bz=0 xr=1 rv=0",
               busy, x_ready, r_valid);
    end
    m_loaded = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    w_valid = 1;
    repeat (3) @(negedge clk);
    check_all_zero("reset_initial");
    @(posedge clk); #2;
    rst_n = 1; w_valid = 0;
    @(negedge clk);
    checks++;
    if (x_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_release got xr=%b bz=%b required xr=1 bz=0",
               x_ready, busy);
    end
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check_all_zero("reset_idle");
    @(posedge clk); #2;
    rst_n = 1;
    m_loaded = 0;
  endtask

  task automatic test_reset_mid_run();
    int t, bad;
    bit ok;
    send_x(0, $urandom, t, ok);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check_all_zero("reset_mid_run");
    @(posedge clk); #2;
    rst_n = 1;
    m_loaded = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r_valid || start || busy || !x_ready) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_abort got=%0d bad cycles required=0", bad);
    end
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] wv [NW];
    int hc [NW];
    int t, got;
    bit ok;
    for (int i = 0; i < NW; i++) wv[i] = 8'($urandom);
    send_x(1, $urandom, t, ok);
    feed_w(0, 3, wv, hc, got);
    rst_n = 0;
    #1;
    check_all_zero("reset_mid_load");
    @(posedge clk); #2;
    rst_n = 1;
    m_loaded = 0;
    run_job(0, 2, 0);
  endtask

  initial begin
    test_reset();
    run_job(0, 0, 0);
    run_job(0, 0, 0);
    run_job(1, 1, 0);
    run_job(0, 0, 5);
    run_job(0, 2, 0);
    test_reset_mid_run();
    test_reset_mid_load();
    for (int i = 0; i < 8; i++)
      run_job(1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
